// File: rtl/fs_iter_sub.sv
`default_nettype none
// ============================================================================
//  Module      : fs_iter_sub
//  Description : Iterative full subtractor. Computes Diff = A - B - Bin one
//                SLICE-bit chunk per clock, LSB chunk first, with the borrow
//                registered between chunks. Valid/ready on both sides.
//                Optional flag outputs (zero/neg/ovf) when the macro
//                FS_ITER_SUB_FLAGS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module fs_iter_sub #(
    parameter int WIDTH = 64,   // must be a multiple of SLICE
    parameter int SLICE = 16    // 1 <= SLICE <= WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef FS_ITER_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operands are shifted right one slice per busy cycle so the active
    // chunk always sits in the low SLICE bits; the result is shifted in from
    // the top and lands LSB-aligned after the last slice.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [IDXW-1:0]  r_idx;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE:0]   w_sub;
    logic [WIDTH-1:0] w_diff_nxt;
    logic             w_last;

`ifdef FS_ITER_SUB_FLAGS_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_zero;
    logic r_neg;
    logic r_ovf;
`endif

    // One slice of ripple subtract using only the registered borrow
    always_comb begin
        w_a_sl     = r_a[SLICE-1:0];
        w_b_sl     = r_b[SLICE-1:0];
        w_sub      = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{SLICE{1'b0}}, r_borrow};
        w_diff_nxt = (r_diff >> SLICE) | (WIDTH'(w_sub[SLICE-1:0]) << (WIDTH - SLICE));
        w_last     = (r_idx == C_LAST_IDX);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, per-slice datapath update and final result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_idx    <= '0;
`ifdef FS_ITER_SUB_FLAGS_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= Bin;
                        r_idx    <= '0;
`ifdef FS_ITER_SUB_FLAGS_EN
                        r_a_msb  <= A[WIDTH-1];
                        r_b_msb  <= B[WIDTH-1];
`endif
                    end
                end
                S_BUSY: begin
                    r_a      <= r_a >> SLICE;
                    r_b      <= r_b >> SLICE;
                    r_diff   <= w_diff_nxt;
                    r_borrow <= w_sub[SLICE];
                    if (w_last) begin
                        r_idx  <= '0;
                        r_bout <= w_sub[SLICE];
`ifdef FS_ITER_SUB_FLAGS_EN
                        // Last slice holds Diff's MSB, so flags use it directly
                        r_zero <= ~|w_diff_nxt;
                        r_neg  <= w_sub[SLICE-1];
                        r_ovf  <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_sub[SLICE-1]);
`endif
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Diff = r_diff;
    assign Bout = r_bout;

`ifdef FS_ITER_SUB_FLAGS_EN
    assign zero = r_zero;
    assign neg  = r_neg;
    assign ovf  = r_ovf;
`endif

endmodule
`default_nettype wire
